arith_alu_seq: RTL
==================

// Module: arith_alu_seq
// PURPOSE
//  Parametrised, registered successor to the combinational integer ALU.
//  - Same 4-bit micro-op encoding, any even WIDTH.
//  - valid/ready handshakes on the operand and result sides.
//  - Corrected signed/unsigned compares, true carry-out for ADDC, arithmetic SAR.
//  - MUL is an iterative multi-cycle multiplier; all other ops complete in 1 cycle.
//  - Sits between the uop decode/issue stage and register writeback.
// PARAMETERS
//  WIDTH       64  operand/result width; even, >=8
//  MUL_BPC     4   multiplier bits retired per cycle; divides WIDTH
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  in_valid    in   1      operand beat valid
//  in_ready    out  1      block accepts a beat this cycle
//  opMode      in   4      0 NONE,1 ADD,2 SUB,3 MUL,4 AND,5 OR,6 XOR,7 SHL,8 SHR,9 SAR,A ADDC,B CMPEQ,C CMPGT,D CMPGE,E CMPHS,F CMPHI
//  srca        in   WIDTH  operand A
//  srcb        in   WIDTH  operand B
//  sri         in   4      status in; sri[0] = carry-in for ADDC
//  out_valid   out  1      result beat valid
//  out_ready   in   1      consumer takes result this cycle
//  dst         out  WIDTH  result
//  sro         out  4      status out
//  busy        out  1      multiply in progress
// BEHAVIOUR
//  - Reset: out_valid=0, dst=0, sro=0, busy=0; in_ready=1 the cycle after reset drops.
//    Reset mid-multiply aborts the multiply and discards the result.
//  - Accept: in_valid & in_ready.
//    in_ready = !busy & (!out_valid | out_ready), so 1-cycle ops sustain 1 op/clk.
//  - Output hold: out_valid stays high and dst/sro stay stable until out_ready.
//  - States:
//    - IDLE -> IDLE on accepted non-MUL op; result registered, out_valid the next cycle (latency 1).
//    - IDLE -> MUL on accepted MUL; busy=1, operands latched.
//    - MUL -> IDLE after WIDTH/MUL_BPC cycles; out_valid rises that edge, so latency = WIDTH/MUL_BPC.
//    - While in MUL, in_ready=0 and input changes are ignored.
//  - Arithmetic: all ops modulo 2^WIDTH. MUL returns the low WIDTH bits of the unsigned product.
//  - Shifts: amount = srcb[$clog2(WIDTH)-1:0]. SHL/SHR fill with 0; SAR sign-fills from srca[WIDTH-1].
//  - Status, H = WIDTH/2:
//    - ops 0-9: sro=sri.
//    - ADDC: dst = srca + srcb + sri[0]; sro[0] = carry out of bit H-1; sro[1] = carry out of bit WIDTH-1.
//    - CMPxx: dst = srca; sro[0] = compare on low H bits; sro[1] = compare on full width.
//      EQ ==, GT signed >, GE signed >=, HS unsigned >=, HI unsigned >.
//    - ADDC/CMP: sro[3:2] = sri[3:2].
//  - NONE: dst=0, sro=sri, still handshakes.
// CONFIGURATION
//  ARITH_ALU_SEQ_MUL_EN
//  - Defined: iterative multiplier as above.
//  - Undefined: no multiplier logic. MUL completes in 1 cycle with dst=0, sro=sri, busy tied 0.
// TESTING
//  1. reset high 3 clk, any inputs -> out_valid=0, dst=0, sro=0, busy=0; in_ready=1 after release.
//  2. ADD 0xFFFF_FFFF_FFFF_FFFF+1, then 4 back-to-back ops, out_ready=1
//     -> dst=0, sro=sri; out_valid on consecutive cycles; 1 result/clk.
//  3. ADDC srca=0x0000_0000_FFFF_FFFF, srcb=0, sri=1 -> dst=0x0000_0001_0000_0000, sro[0]=1, sro[1]=0.
//  4. CMPGT vs CMPHI, srca=0xFFFF_FFFF_FFFF_FFFF, srcb=1:
//     - CMPGT -> sro[1:0]=00.
//     - CMPHI -> sro[1:0]=11.
//  5. MUL 0x1234_5678 x 0x10 (MUL_EN defined)
//     -> busy 16 clk, in_ready=0 throughout, then dst=0x1_2345_6780.
//     Repeat with reset asserted at cycle 5 -> no out_valid.
//  6. SAR srca=0x8000_0000_0000_0000, srcb=0x43 (amount 3), out_ready=0 for 4 clk
//     -> dst=0xF000_0000_0000_0000 held stable with out_valid=1 and in_ready=0 until out_ready.

Source files
------------

// File: rtl/arith_alu_seq.sv
// rtl/arith_alu_seq.sv - registered integer ALU with valid/ready handshakes
// Optional iterative multiplier enabled by defining ARITH_ALU_SEQ_MUL_EN.
module arith_alu_seq #(
    parameter int WIDTH   = 64,
    parameter int MUL_BPC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opMode,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [3:0]       sri,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dst,
    output logic [3:0]       sro,
    output logic             busy
);

    localparam int H  = WIDTH / 2;
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_NONE  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_SAR   = 4'h9;
    localparam logic [3:0] OP_ADDC  = 4'hA;
    localparam logic [3:0] OP_CMPEQ = 4'hB;
    localparam logic [3:0] OP_CMPGT = 4'hC;
    localparam logic [3:0] OP_CMPGE = 4'hD;
    localparam logic [3:0] OP_CMPHS = 4'hE;
    localparam logic [3:0] OP_CMPHI = 4'hF;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [3:0]       sro_q, sro_d;

    logic             accept;
    logic             start_alu;
    logic             mul_done;
    logic [WIDTH-1:0] mul_dst;
    logic [3:0]       mul_sro;

    logic [WIDTH-1:0] alu_dst;
    logic [3:0]       alu_sro;
    logic [WIDTH:0]   add_full;
    logic [H:0]       add_lo;
    logic [SW-1:0]    shamt;
    logic             cmp_lo, cmp_full;

    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign shamt    = srcb[SW-1:0];
    assign add_full = {1'b0, srca} + {1'b0, srcb} + {{WIDTH{1'b0}}, sri[0]};
    assign add_lo   = {1'b0, srca[H-1:0]} + {1'b0, srcb[H-1:0]} + {{H{1'b0}}, sri[0]};

    always_comb begin
        cmp_lo   = 1'b0;
        cmp_full = 1'b0;
        case (opMode)
            OP_CMPEQ: begin
                cmp_lo   = srca[H-1:0] == srcb[H-1:0];
                cmp_full = srca == srcb;
            end
            OP_CMPGT: begin
                cmp_lo   = $signed(srca[H-1:0]) > $signed(srcb[H-1:0]);
                cmp_full = $signed(srca) > $signed(srcb);
            end
            OP_CMPGE: begin
                cmp_lo   = $signed(srca[H-1:0]) >= $signed(srcb[H-1:0]);
                cmp_full = $signed(srca) >= $signed(srcb);
            end
            OP_CMPHS: begin
                cmp_lo   = srca[H-1:0] >= srcb[H-1:0];
                cmp_full = srca >= srcb;
            end
            OP_CMPHI: begin
                cmp_lo   = srca[H-1:0] > srcb[H-1:0];
                cmp_full = srca > srcb;
            end
            default: begin
                cmp_lo   = 1'b0;
                cmp_full = 1'b0;
            end
        endcase
    end

    // MUL lands in the default arm: with the multiplier disabled it yields dst=0, sro=sri.
    always_comb begin
        alu_dst = '0;
        alu_sro = sri;
        case (opMode)
            OP_NONE: alu_dst = '0;
            OP_ADD:  alu_dst = srca + srcb;
            OP_SUB:  alu_dst = srca - srcb;
            OP_AND:  alu_dst = srca & srcb;
            OP_OR:   alu_dst = srca | srcb;
            OP_XOR:  alu_dst = srca ^ srcb;
            OP_SHL:  alu_dst = srca << shamt;
            OP_SHR:  alu_dst = srca >> shamt;
            OP_SAR:  alu_dst = WIDTH'($signed(srca) >>> shamt);
            OP_ADDC: begin
                alu_dst = add_full[WIDTH-1:0];
                alu_sro = {sri[3:2], add_full[WIDTH], add_lo[H]};
            end
            OP_CMPEQ, OP_CMPGT, OP_CMPGE, OP_CMPHS, OP_CMPHI: begin
                alu_dst = srca;
                alu_sro = {sri[3:2], cmp_full, cmp_lo};
            end
            default: alu_dst = '0;
        endcase
    end

`ifdef ARITH_ALU_SEQ_MUL_EN
    localparam int N  = WIDTH / MUL_BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       msri_q, msri_d;
    logic [WIDTH-1:0] digit;
    logic             is_mul;

    assign is_mul    = opMode == OP_MUL;
    assign start_alu = accept && !is_mul;
    assign busy      = state_q == S_MUL;
    assign digit     = {{(WIDTH-MUL_BPC){1'b0}}, mplier_q[MUL_BPC-1:0]};
    assign mul_dst   = acc_d;
    assign mul_sro   = msri_q;

    // Radix-2^MUL_BPC shift-and-add: retire the low multiplier digit each cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        msri_d   = msri_q;
        mul_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = srca;
                    mplier_d = srcb;
                    acc_d    = '0;
                    msri_d   = sri;
                end
            end
            S_MUL: begin
                acc_d    = acc_q + mcand_q * digit;
                mcand_d  = mcand_q << MUL_BPC;
                mplier_d = mplier_q >> MUL_BPC;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    mul_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            msri_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            msri_q   <= msri_d;
        end
    end
`else
    assign start_alu = accept;
    assign busy      = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_dst   = '0;
    assign mul_sro   = '0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        dst_d       = dst_q;
        sro_d       = sro_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (start_alu) begin
            out_valid_d = 1'b1;
            dst_d       = alu_dst;
            sro_d       = alu_sro;
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            dst_d       = mul_dst;
            sro_d       = mul_sro;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dst_q       <= '0;
            sro_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dst_q       <= dst_d;
            sro_q       <= sro_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dst       = dst_q;
    assign sro       = sro_q;

endmodule
